csa_pipe: RTL and testbench

Parametrised, pipelined conditional-sum adder/subtractor with valid/ready flow control on both sides. It generalises the combinational N-bit CSA into WIDTH bits split into CHUNK-bit slices, with one slice's carry resolved per pipeline stage. Throughput is one operation per clock. It serves as the arithmetic datapath building block for later lab designs on the BASYS3 target.

---
 rtl/csa_pipe_pkg.sv | 26 ++
 rtl/csa_chunk.sv | 35 +++
 rtl/csa_fa.sv | 15 +
 rtl/csa_pipe.sv | 136 +++++++++++++
 tb/tb_csa_pipe.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/csa_pipe_pkg.sv
// csa_pipe_pkg: shared constants, the pipeline-depth derivation and the
// stage-register record for the csa_pipe conditional-sum adder.
//   DEF_WIDTH / DEF_CHUNK : default operand and slice widths
//   csa_nch()             : number of pipeline stages (slices) for a geometry
//   csa_stage_t           : stage record at the default geometry
package csa_pipe_pkg;

    localparam int unsigned DEF_WIDTH = 16;
    localparam int unsigned DEF_CHUNK = 4;

    function automatic int unsigned csa_nch(input int unsigned width,
                                            input int unsigned chunk);
        return width / chunk;
    endfunction

    // Stage record at the default geometry; csa_pipe declares the same layout
    // sized by its own WIDTH parameter.
    typedef struct packed {
        logic                 valid;
        logic [DEF_WIDTH-1:0] a;
        logic [DEF_WIDTH-1:0] b;
        logic [DEF_WIDTH-1:0] psum;
        logic                 carry;
    } csa_stage_t;

endpackage

// File: rtl/csa_chunk.sv
// csa_chunk: combinational CHUNK-bit conditional-sum slice. Produces the slice
// result for both possible carry-ins so the caller only has to select.
//   a, b       : slice operands
//   sum0, c0   : result and carry-out assuming carry-in 0
//   sum1, c1   : result and carry-out assuming carry-in 1
module csa_chunk #(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    output logic [CHUNK-1:0] sum0,
    output logic             c0,
    output logic [CHUNK-1:0] sum1,
    output logic             c1
);

    // Per-bit carry nets live in each generate block so the two ripple
    // chains stay separate signals rather than one self-dependent vector.
    for (genvar i = 0; i < CHUNK; i++) begin : g_bit
        logic ci0, ci1, co0, co1;
        if (i == 0) begin : g_lsb
            assign ci0 = 1'b0;
            assign ci1 = 1'b1;
        end else begin : g_mid
            assign ci0 = g_bit[i-1].co0;
            assign ci1 = g_bit[i-1].co1;
        end
        csa_fa u_fa0 (.a(a[i]), .b(b[i]), .ci(ci0), .s(sum0[i]), .co(co0));
        csa_fa u_fa1 (.a(a[i]), .b(b[i]), .ci(ci1), .s(sum1[i]), .co(co1));
    end

    assign c0 = g_bit[CHUNK-1].co0;
    assign c1 = g_bit[CHUNK-1].co1;

endmodule

// File: rtl/csa_fa.sv
// csa_fa: single-bit full adder, the leaf cell of csa_chunk.
//   a, b, ci : addend bits and carry-in
//   s, co    : sum bit and carry-out
module csa_fa (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/csa_pipe.sv
// csa_pipe: pipelined conditional-sum adder/subtractor, one CHUNK-bit slice
// resolved per stage, valid/ready handshake on both sides.
//   clk, rst_n           : clock, synchronous active-low reset
//   in_valid, in_ready   : operand handshake
//   a, b, ci, sub        : operands; sub=1 gives a-b (ci ignored)
//   out_valid, out_ready : result handshake
//   sum, co              : result mod 2^WIDTH, carry-out (1 = no borrow)
//   ovf                  : signed overflow, only when CSA_PIPE_OVF_EN is defined
module csa_pipe
    import csa_pipe_pkg::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             co
`ifdef CSA_PIPE_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NCH = csa_nch(WIDTH, CHUNK);

    if (CHUNK == 0 || WIDTH == 0 || (WIDTH % CHUNK) != 0) begin : g_bad_geometry
        $error("csa_pipe: WIDTH must be a non-zero multiple of CHUNK");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] psum;
        logic             carry;
`ifdef CSA_PIPE_OVF_EN
        logic             ovf;
`endif
    } stage_t;

    stage_t         st     [1:NCH];
    stage_t         nxt_st [1:NCH];
    logic [NCH:1]   v;
    logic [NCH:1]   adv;

    // Slice s is resolved on the way into stage s+1; slice 0 straight from the ports.
    for (genvar s = 0; s < NCH; s++) begin : g_slice
        stage_t           src;
        stage_t           nxt;
        logic [CHUNK-1:0] s0, s1;
        logic             c0, c1;

        if (s == 0) begin : g_in
            always_comb begin
                src       = '0;
                src.valid = 1'b1;
                src.a     = a;
                src.b     = sub ? ~b : b;
                src.carry = sub | ci;
            end
        end else begin : g_reg
            assign src = st[s];
        end

        csa_chunk #(.CHUNK(CHUNK)) u_chunk (
            .a    (src.a[s*CHUNK +: CHUNK]),
            .b    (src.b[s*CHUNK +: CHUNK]),
            .sum0 (s0),
            .c0   (c0),
            .sum1 (s1),
            .c1   (c1)
        );

        always_comb begin
            nxt                          = src;
            nxt.valid                    = 1'b1;
            nxt.psum[s*CHUNK +: CHUNK]   = src.carry ? s1 : s0;
            nxt.carry                    = src.carry ? c1 : c0;
`ifdef CSA_PIPE_OVF_EN
            // a^b^sum at the MSB recovers the carry into the MSB.
            if (s == NCH - 1)
                nxt.ovf = src.a[WIDTH-1] ^ src.b[WIDTH-1] ^ nxt.psum[WIDTH-1] ^ nxt.carry;
`endif
        end

        assign nxt_st[s+1] = nxt;
    end

    // Walk from the output back to the input: "room" is whether the stage
    // downstream of k can take a new entry this cycle.
    always_comb begin
        logic        room;
        int unsigned k;
        v    = '0;
        adv  = '0;
        room = out_ready;
        k    = 0;
        for (int unsigned i = 1; i <= NCH; i++) v[i] = st[i].valid;
        for (int unsigned i = 0; i < NCH; i++) begin
            k      = NCH - i;
            adv[k] = v[k] & room;
            room   = !v[k] | adv[k];
        end
        in_ready = rst_n & room;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int unsigned k = 1; k <= NCH; k++) st[k] <= '0;
        end else begin
            if (in_valid && in_ready) st[1] <= nxt_st[1];
            else if (adv[1])          st[1].valid <= 1'b0;
            for (int unsigned k = 2; k <= NCH; k++) begin
                if (adv[k-1])    st[k] <= nxt_st[k];
                else if (adv[k]) st[k].valid <= 1'b0;
            end
        end
    end

    assign out_valid = st[NCH].valid;
    assign sum       = st[NCH].psum;
    assign co        = st[NCH].carry;
`ifdef CSA_PIPE_OVF_EN
    assign ovf       = st[NCH].ovf;
`endif

endmodule

// File: tb/tb_csa_pipe.sv
// tb_csa_pipe: self-checking bench for csa_pipe at the default geometry.
// Expected results come from a plain-arithmetic model queued at acceptance.
module tb_csa_pipe;

    localparam int unsigned W   = 16;
    localparam int unsigned NCH = 4;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a, b;
    logic         ci, sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         co;
`ifdef CSA_PIPE_OVF_EN
    logic         ovf;
`endif

    csa_pipe #(.WIDTH(W), .CHUNK(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .ci        (ci),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .co        (co)
`ifdef CSA_PIPE_OVF_EN
        ,
        .ovf       (ovf)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         co;
        logic         ovf;
        int           cyc;
    } exp_t;

    exp_t         q[$];
    int           n_checks = 0;
    int           n_errors = 0;
    int           cyc      = 0;
    int           n_acc    = 0;
    int           n_out    = 0;
    logic         lat_chk  = 1'b0;
    logic         last_acc, last_out;
    logic         held_v   = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_co;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: integer add of a, (~b or b), and the effective carry-in.
    function automatic exp_t model(input logic [W-1:0] oa, input logic [W-1:0] ob,
                                   input logic oci, input logic osub);
        exp_t         e;
        logic [W-1:0] bx;
        logic [W:0]   tot;
        bx    = osub ? ~ob : ob;
        tot   = {1'b0, oa} + {1'b0, bx} + ((osub || oci) ? (W+1)'(1) : (W+1)'(0));
        e.sum = tot[W-1:0];
        e.co  = tot[W];
        e.ovf = (oa[W-1] == bx[W-1]) && (e.sum[W-1] != oa[W-1]);
        e.cyc = 0;
        return e;
    endfunction

    task automatic step(input logic r, input logic iv, input logic [W-1:0] ia,
                        input logic [W-1:0] ib, input logic ici, input logic isub,
                        input logic ordy, input logic use_exp, input logic [W-1:0] esum,
                        input logic eco, input logic eovf);
        exp_t e;
        @(negedge clk);
        rst_n = r; in_valid = iv; a = ia; b = ib; ci = ici; sub = isub; out_ready = ordy;
        #1;
        cyc++;
        last_acc = in_valid & in_ready;
        last_out = out_valid & out_ready;
        if (held_v && out_valid) begin
            check("hold_sum", 32'(sum), 32'(held_sum));
            check("hold_co", 32'(co), 32'(held_co));
        end
        held_v   = out_valid & !out_ready;
        held_sum = sum;
        held_co  = co;
        if (last_out) begin
            if (q.size() == 0) begin
                check("spurious_out", 32'(out_valid), 32'(0));
            end else begin
                e = q.pop_front();
                check("sum", 32'(sum), 32'(e.sum));
                check("co", 32'(co), 32'(e.co));
`ifdef CSA_PIPE_OVF_EN
                check("ovf", 32'(ovf), 32'(e.ovf));
`endif
                if (lat_chk) check("latency", 32'(cyc - e.cyc), 32'(NCH));
                n_out++;
            end
        end
        if (last_acc) begin
            e = model(ia, ib, ici, isub);
            if (use_exp) begin
                e.sum = esum; e.co = eco; e.ovf = eovf;
            end
            e.cyc = cyc;
            q.push_back(e);
            n_acc++;
        end
        if (!r) begin
            q.delete();
            held_v = 1'b0;
        end
    endtask

    task automatic idle(input logic ordy);
        step(1'b1, 1'b0, '0, '0, 1'b0, 1'b0, ordy, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic rnd_op(input logic ordy);
        logic [W-1:0] ra, rb;
        ra = W'($urandom);
        rb = W'($urandom);
        step(1'b1, 1'b1, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ordy, 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < 40 && q.size() != 0; i++) idle(1'b1);
        check("drain_empty", 32'(q.size()), 32'(0));
    endtask

    initial begin
        int acc0, out0;
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; ci = 1'b0; sub = 1'b0; out_ready = 1'b1;

        // Reset held with in_valid asserted.
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 1'b1, 16'h1111, 16'h2222, 1'b1, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
            check("rst_out_valid", 32'(out_valid), 32'(0));
            check("rst_sum", 32'(sum), 32'(0));
            check("rst_co", 32'(co), 32'(0));
            check("rst_in_ready", 32'(in_ready), 32'(0));
`ifdef CSA_PIPE_OVF_EN
            check("rst_ovf", 32'(ovf), 32'(0));
`endif
        end
        idle(1'b1);
        check("rel_in_ready", 32'(in_ready), 32'(1));
        check("rel_out_valid", 32'(out_valid), 32'(0));
        for (int i = 0; i < 6; i++) idle(1'b1);
        check("rel_nothing_out", 32'(n_out), 32'(0));

        // Directed: full carry chain, plain add, subtract (ci ignored).
        lat_chk = 1'b1;
        step(1'b1, 1'b1, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
        step(1'b1, 1'b1, 16'h1234, 16'h4321, 1'b1, 1'b0, 1'b1, 1'b1, 16'h5556, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h0005, 16'h0007, 1'b1, 1'b1, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        step(1'b1, 1'b1, 16'h8000, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1);
        drain();
        check("directed_count", 32'(n_out), 32'(4));

        // Streaming: one operation per cycle.
        acc0 = n_acc; out0 = n_out;
        for (int i = 0; i < 200; i++) rnd_op(1'b1);
        check("stream_accepts", 32'(n_acc - acc0), 32'(200));
        check("stream_rate", 32'(n_out - out0), 32'(200 - NCH));
        drain();
        check("stream_outputs", 32'(n_out - out0), 32'(200));

        // Backpressure: stalled consumer fills the pipe, then drain while accepting.
        lat_chk = 1'b0;
        acc0 = n_acc; out0 = n_out;
        for (int i = 0; i < 10; i++) rnd_op(1'b0);
        check("bp_accepts", 32'(n_acc - acc0), 32'(NCH));
        check("bp_in_ready", 32'(in_ready), 32'(0));
        check("bp_out_valid", 32'(out_valid), 32'(1));
        rnd_op(1'b1);
        check("bp_same_cycle_acc", 32'(last_acc), 32'(1));
        check("bp_same_cycle_out", 32'(last_out), 32'(1));
        drain();
        check("bp_outputs", 32'(n_out - out0), 32'(NCH + 1));

        // Reset with three operations in flight.
        lat_chk = 1'b1;
        for (int i = 0; i < 3; i++) rnd_op(1'b1);
        out0 = n_out;
        step(1'b0, 1'b0, '0, '0, 1'b0, 1'b0, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle(1'b1);
        check("mid_rst_out_valid", 32'(out_valid), 32'(0));
        check("mid_rst_in_ready", 32'(in_ready), 32'(1));
        for (int i = 0; i < 10; i++) idle(1'b1);
        check("mid_rst_discarded", 32'(n_out - out0), 32'(0));

        // Pipe still works after the mid-flight reset.
        for (int i = 0; i < 8; i++) rnd_op(1'b1);
        drain();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
